// File: rtl/serializador_cola_if.sv
// serializador_cola_if: buffer-head and narrow-stream signals of the drain stage
interface serializador_cola_if #(
   parameter int WIDTH     = 64,
   parameter int OUT_WIDTH = 16
);
   logic [WIDTH-1:0]     dato_i;
   logic                 vacia_i;
   logic                 delecion_o;
   logic [OUT_WIDTH-1:0] dato_o;
   logic                 valido_o;
   logic                 listo_i;
   logic                 ultimo_o;
   logic                 ocupado_o;
   modport master (
      input  dato_i, vacia_i, listo_i,
      output delecion_o, dato_o, valido_o, ultimo_o, ocupado_o
   );
   modport slave (
      output dato_i, vacia_i, listo_i,
      input  delecion_o, dato_o, valido_o, ultimo_o, ocupado_o
   );
endinterface

// File: rtl/serializador_cola.sv
// serializador_cola: pops buffer words and streams them out LSB chunk first
module serializador_cola #(
   parameter int WIDTH     = 64,
   parameter int OUT_WIDTH = 16
) (
   input logic                clk_i,
   input logic                rst_i,
   serializador_cola_if.master bus
);
   localparam int R        = WIDTH / OUT_WIDTH;
   localparam int CNT_SIZE = $clog2(R);
   typedef enum logic {LIBRE, ENVIO} estado_t;
   estado_t             estado;
   logic [WIDTH-1:0]    sh_q;
   logic [CNT_SIZE-1:0] cnt_q;
   logic                valido, ultimo, acep, carga;
   // Handshake terms; everything is masked while reset is held so nothing leaks out
   always_comb begin
      valido = ~rst_i & (estado == ENVIO);
      ultimo = valido & (cnt_q == CNT_SIZE'(R - 1));
      acep   = valido & bus.listo_i;
      carga  = ~rst_i & ~bus.vacia_i & ((estado == LIBRE) | (acep & ultimo));
   end
   assign bus.dato_o     = rst_i ? '0 : sh_q[OUT_WIDTH-1:0];
   assign bus.valido_o   = valido;
   assign bus.ocupado_o  = valido;
   assign bus.ultimo_o   = ultimo;
   assign bus.delecion_o = carga;
   // Load a new head word, shift on each accepted chunk, or fall idle after the last one
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         estado <= LIBRE;
         sh_q   <= '0;
         cnt_q  <= '0;
      end else if (carga) begin
         estado <= ENVIO;
         sh_q   <= bus.dato_i;
         cnt_q  <= '0;
      end else if (acep) begin
         if (ultimo) begin
            estado <= LIBRE;
            cnt_q  <= '0;
         end else begin
            sh_q  <= sh_q >> OUT_WIDTH;
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_serializador_cola.sv
// tb_serializador_cola: directed scenarios with a small queue standing in for the buffer
module tb_serializador_cola;
   localparam logic [63:0] W1 = 64'h4444_3333_2222_1111;
   localparam logic [63:0] W2 = 64'h8888_7777_6666_5555;
   localparam logic [63:0] WA = 64'h0003_0002_0001_0000;
   localparam logic [63:0] WB = 64'h0007_0006_0005_0004;
   logic clk = 0;
   logic rst = 1;
   int   tests = 0;
   int   fails = 0;
   logic [63:0] q[$];
   serializador_cola_if #(.WIDTH(64), .OUT_WIDTH(16)) bus ();
   serializador_cola #(.WIDTH(64), .OUT_WIDTH(16)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
   always #5 clk = ~clk;

   task automatic refresh();
      bus.vacia_i = (q.size() == 0);
      bus.dato_i  = (q.size() != 0) ? q[0] : 64'd0;
   endtask

   task automatic push(input logic [63:0] w);
      q.push_back(w);
      refresh();
      #1;
   endtask

   task automatic tick();
      logic pop;
      #1;
      pop = bus.delecion_o;
      @(posedge clk);
      #1;
      if (pop) void'(q.pop_front());
      refresh();
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic test_reset();
      bus.listo_i = 1;
      rst = 1;
      push(W1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("reset_delecion", bus.delecion_o, 0);
         chk("reset_valido", bus.valido_o, 0);
         chk("reset_ultimo", bus.ultimo_o, 0);
         chk("reset_dato", bus.dato_o, 0);
         chk("reset_ocupado", bus.ocupado_o, 0);
      end
      rst = 0;
      #1;
      chk("reset_first_pop", bus.delecion_o, 1);
   endtask

   task automatic test_single();
      logic [15:0] exp[4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
      tick();
      for (int k = 0; k < 4; k++) begin
         chk("single_valido", bus.valido_o, 1);
         chk("single_dato", bus.dato_o, exp[k]);
         chk("single_ultimo", bus.ultimo_o, k == 3);
         chk("single_delecion", bus.delecion_o, 0);
         tick();
      end
      chk("single_idle_valido", bus.valido_o, 0);
      chk("single_idle_ocupado", bus.ocupado_o, 0);
   endtask

   task automatic test_back_to_back();
      push(WA);
      push(WB);
      chk("b2b_first_pop", bus.delecion_o, 1);
      tick();
      for (int i = 0; i < 8; i++) begin
         chk("b2b_valido", bus.valido_o, 1);
         chk("b2b_dato", bus.dato_o, 64'(i));
         chk("b2b_ultimo", bus.ultimo_o, (i % 4) == 3);
         chk("b2b_delecion", bus.delecion_o, i == 3);
         tick();
      end
      chk("b2b_end_valido", bus.valido_o, 0);
   endtask

   task automatic test_backpressure();
      push(W1);
      tick();
      tick();
      tick();
      chk("bp_pre_dato", bus.dato_o, 16'h3333);
      bus.listo_i = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_dato", bus.dato_o, 16'h3333);
         chk("bp_valido", bus.valido_o, 1);
         chk("bp_ultimo", bus.ultimo_o, 0);
         chk("bp_delecion", bus.delecion_o, 0);
      end
      bus.listo_i = 1;
      tick();
      chk("bp_resume_dato", bus.dato_o, 16'h4444);
      chk("bp_resume_ultimo", bus.ultimo_o, 1);
      tick();
      chk("bp_end_valido", bus.valido_o, 0);
   endtask

   task automatic test_last_stall();
      push(W1);
      push(W2);
      tick();
      tick();
      tick();
      tick();
      bus.listo_i = 0;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("stall_dato", bus.dato_o, 16'h4444);
         chk("stall_ultimo", bus.ultimo_o, 1);
         chk("stall_delecion", bus.delecion_o, 0);
         tick();
      end
      bus.listo_i = 1;
      #1;
      chk("stall_release_pop", bus.delecion_o, 1);
      tick();
      chk("stall_next_dato", bus.dato_o, 16'h5555);
      chk("stall_next_ultimo", bus.ultimo_o, 0);
      for (int i = 0; i < 4; i++) tick();
      chk("stall_end_valido", bus.valido_o, 0);
   endtask

   task automatic test_empty();
      for (int i = 0; i < 2; i++) begin
         chk("empty_delecion", bus.delecion_o, 0);
         chk("empty_valido", bus.valido_o, 0);
         tick();
      end
   endtask

   task automatic test_reset_mid();
      push(W1);
      push(W2);
      tick();
      tick();
      chk("mid_pre_dato", bus.dato_o, 16'h2222);
      rst = 1;
      tick();
      chk("mid_valido", bus.valido_o, 0);
      chk("mid_delecion", bus.delecion_o, 0);
      rst = 0;
      #1;
      chk("mid_pop", bus.delecion_o, 1);
      tick();
      chk("mid_restart_dato", bus.dato_o, 16'h5555);
      chk("mid_restart_valido", bus.valido_o, 1);
      for (int i = 0; i < 4; i++) tick();
      chk("mid_end_valido", bus.valido_o, 0);
      chk("mid_queue_empty", 64'(q.size()), 0);
   endtask

   initial begin
      bus.listo_i = 1;
      refresh();
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_last_stall();
      test_empty();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
